pll_phase_step_ctrl: RTL

- Single-clock sequencer that drives the PLL dynamic phase-shift inputs: PHASE_SEL, PHASE_DIR, PHASE_STEP_N and LOAD_PHASE.
- Accepts phase-move requests over a valid/ready handshake. Each request is an output select, a direction and a step count.
- Emits spaced active-low step pulses, then confirms the PLL is still locked before it reports done.
- Sits between control logic (register bank / calibration FSM) and the PLL wrapper.

---
 rtl/pll_phase_step_ctrl.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/pll_phase_step_ctrl.sv
// rtl/pll_phase_step_ctrl.sv - PLL dynamic phase-shift step sequencer (optional PLL_PHASE_POS_TRACK_EN)
module pll_phase_step_ctrl #(
  parameter int STEP_LO_CYC  = 2,
  parameter int GAP_CYC      = 4,
  parameter int LOCK_TIMEOUT = 1024,
  parameter int CNT_W        = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_sel,
  input  logic             req_dir,
  input  logic [CNT_W-1:0] req_steps,
  input  logic             pll_lock,
  output logic [2:0]       phase_sel,
  output logic             phase_dir,
  output logic             phase_step_n,
  output logic             load_phase,
  output logic             done,
  output logic             err,
  output logic [1:0]       err_code,
  output logic             busy
`ifdef PLL_PHASE_POS_TRACK_EN
  , output logic [5*13-1:0] pos_o
`endif
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_SETUP     = 3'd1;
  localparam logic [2:0] S_STEP_LO   = 3'd2;
  localparam logic [2:0] S_GAP       = 3'd3;
  localparam logic [2:0] S_LOAD      = 3'd4;
  localparam logic [2:0] S_WAIT_LOCK = 3'd5;

  localparam int PW_MAX = (STEP_LO_CYC > GAP_CYC) ? STEP_LO_CYC : GAP_CYC;
  localparam int TW     = $clog2(PW_MAX + 1);
  localparam int TO_W   = $clog2(LOCK_TIMEOUT + 1);

  localparam logic [TW-1:0]   LO_LAST  = TW'(STEP_LO_CYC - 1);
  localparam logic [TW-1:0]   GAP_LAST = TW'(GAP_CYC - 1);
  localparam logic [TO_W-1:0] TO_LAST  = TO_W'(LOCK_TIMEOUT - 1);
  localparam logic [TO_W-1:0] TO_MAX   = TO_W'(LOCK_TIMEOUT);

  logic [2:0]       state;
  logic [TW-1:0]    tmr;
  logic [TO_W-1:0]  to_cnt;
  logic [CNT_W-1:0] remaining;
  logic             accept;
  logic             stepping;
  logic             step_done;

  assign req_ready = (state == S_IDLE) && pll_lock;
  assign busy      = (state != S_IDLE);
  assign accept    = req_valid && req_ready;
  assign stepping  = (state == S_SETUP) || (state == S_STEP_LO) || (state == S_GAP);
  // A step counts as issued only once its full low time has elapsed with lock held
  assign step_done = (state == S_STEP_LO) && pll_lock && (tmr == LO_LAST);

  // Request sequencer: setup, spaced step pulses, load strobe, then lock confirmation
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      tmr          <= '0;
      to_cnt       <= '0;
      remaining    <= '0;
      phase_sel    <= 3'd0;
      phase_dir    <= 1'b0;
      phase_step_n <= 1'b1;
      load_phase   <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
      err_code     <= 2'd0;
    end else begin
      done       <= 1'b0;
      err        <= 1'b0;
      err_code   <= 2'd0;
      load_phase <= 1'b0;
      if (stepping && !pll_lock) begin
        // Lock lost mid-move: release the step line and abandon without loading
        phase_step_n <= 1'b1;
        err          <= 1'b1;
        err_code     <= 2'd2;
        tmr          <= '0;
        state        <= S_IDLE;
      end else begin
        case (state)
          S_IDLE: begin
            if (accept) begin
              if (req_sel > 3'd4) begin
                err      <= 1'b1;
                err_code <= 2'd1;
              end else if (req_steps == '0) begin
                load_phase <= 1'b1;
                state      <= S_LOAD;
              end else begin
                phase_sel <= req_sel;
                phase_dir <= req_dir;
                remaining <= req_steps;
                state     <= S_SETUP;
              end
            end
          end
          S_SETUP: begin
            phase_step_n <= 1'b0;
            tmr          <= '0;
            state        <= S_STEP_LO;
          end
          S_STEP_LO: begin
            if (tmr == LO_LAST) begin
              phase_step_n <= 1'b1;
              tmr          <= '0;
              if (remaining != '0) remaining <= remaining - CNT_W'(1);
              state        <= S_GAP;
            end else begin
              tmr <= tmr + TW'(1);
            end
          end
          S_GAP: begin
            if (tmr == GAP_LAST) begin
              tmr <= '0;
              if (remaining == '0) begin
                load_phase <= 1'b1;
                state      <= S_LOAD;
              end else begin
                phase_step_n <= 1'b0;
                state        <= S_STEP_LO;
              end
            end else begin
              tmr <= tmr + TW'(1);
            end
          end
          S_LOAD: begin
            to_cnt <= '0;
            state  <= S_WAIT_LOCK;
          end
          S_WAIT_LOCK: begin
            if (pll_lock) begin
              done  <= 1'b1;
              state <= S_IDLE;
            end else if (to_cnt == TO_LAST) begin
              err      <= 1'b1;
              err_code <= 2'd3;
              state    <= S_IDLE;
            end else if (to_cnt != TO_MAX) begin
              to_cnt <= to_cnt + TO_W'(1);
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

`ifdef PLL_PHASE_POS_TRACK_EN
  // Signed per-output phase position, wrapping modulo 2^13
  always_ff @(posedge clk) begin
    if (rst) begin
      pos_o <= '0;
    end else if (step_done) begin
      pos_o[int'(phase_sel)*13 +: 13] <= pos_o[int'(phase_sel)*13 +: 13] +
                                         (phase_dir ? 13'd1 : 13'h1fff);
    end
  end
`endif

endmodule
